// File: rtl/v_red_seq_unit_if.sv
// Handshake bundle for v_red_seq_unit: command, vs2 beat stream and scalar result.
// The slave modport is the reduction engine; the master modport is the execute-stage driver.
interface v_red_seq_unit_if #(
  parameter int LANES = 4,
  parameter int VL_W  = 9
);
  logic                  i_valid;
  logic                  o_ready;
  logic [2:0]            i_op;
  logic [1:0]            i_vsew;
  logic [VL_W-1:0]       i_vl;
  logic [31:0]           i_vs1_e0;
  logic                  i_beat_valid;
  logic                  o_beat_ready;
  logic [32*LANES-1:0]   i_beat_data;
  logic                  o_result_valid;
  logic                  i_result_ready;
  logic [31:0]           o_result;
  logic                  o_error;

  modport slave (
    input  i_valid, i_op, i_vsew, i_vl, i_vs1_e0,
    input  i_beat_valid, i_beat_data, i_result_ready,
    output o_ready, o_beat_ready, o_result_valid, o_result, o_error
  );

  modport master (
    output i_valid, i_op, i_vsew, i_vl, i_vs1_e0,
    output i_beat_valid, i_beat_data, i_result_ready,
    input  o_ready, o_beat_ready, o_result_valid, o_result, o_error
  );
endinterface

// File: rtl/v_red_seq_unit.sv
// Multi-cycle SEW-aware vector reduction (VREDSUM/VREDMAX) folding vs2 beats into vs1[0].
// Define VRED_EXT_OPS_EN to add VREDMIN/VREDAND/VREDOR/VREDXOR.
module v_red_seq_unit #(
  parameter int LANES = 4,
  parameter int VL_W  = 9
) (
  input  logic              clk,
  input  logic              nrst,
  v_red_seq_unit_if.slave   bus
);

  localparam int NE    = LANES * 4;          // elements per beat at SEW=8
  localparam int LVL   = $clog2(NE);
  localparam int NP    = 1 << LVL;           // tree width padded to a power of two
  localparam int CNT_W = VL_W + LVL + 1;

  localparam logic [2:0] OP_SUM = 3'd1;
  localparam logic [2:0] OP_MAX = 3'd2;
`ifdef VRED_EXT_OPS_EN
  localparam logic [2:0] OP_MIN = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Values are carried sign-extended to 32 bits so one ALU serves all SEWs;
  // only the final fold is renormalised to the active SEW.
  function automatic logic [31:0] sext_sew(input logic [1:0] sew, input logic [31:0] v);
    case (sew)
      2'd0:    return {{24{v[7]}}, v[7:0]};
      2'd1:    return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
`ifdef VRED_EXT_OPS_EN
    return (op >= 3'd1) && (op <= 3'd6);
`else
    return (op == OP_SUM) || (op == OP_MAX);
`endif
  endfunction

  function automatic logic [31:0] identity(input logic [2:0] op, input logic [1:0] sew);
    case (op)
      OP_MAX: begin
        case (sew)
          2'd0:    return 32'hFFFF_FF80;
          2'd1:    return 32'hFFFF_8000;
          default: return 32'h8000_0000;
        endcase
      end
`ifdef VRED_EXT_OPS_EN
      OP_MIN: begin
        case (sew)
          2'd0:    return 32'h0000_007F;
          2'd1:    return 32'h0000_7FFF;
          default: return 32'h7FFF_FFFF;
        endcase
      end
      OP_AND:  return 32'hFFFF_FFFF;
`endif
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
`ifdef VRED_EXT_OPS_EN
      OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
`endif
      default: return a + b;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [1:0]         sew_q;
  logic [VL_W-1:0]    vl_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        acc_q;
  logic               err_q;

  logic               cmd_fire;
  logic               cmd_bad;
  logic               beat_fire;
  logic               last_beat;
  logic [CNT_W-1:0]   epb;
  logic [31:0]        ident;
  logic [31:0]        elem [NP];
  logic [31:0]        tree_out;
  logic [31:0]        acc_fold;

  assign cmd_fire  = bus.i_valid && (state_q == S_IDLE);
  assign cmd_bad   = !op_legal(bus.i_op) || (bus.i_vsew == 2'd3);
  assign beat_fire = bus.i_beat_valid && (state_q == S_ACCUM);

  always_comb begin
    case (sew_q)
      2'd0:    epb = CNT_W'(NE);
      2'd1:    epb = CNT_W'(2 * LANES);
      default: epb = CNT_W'(LANES);
    endcase
  end

  assign last_beat = (cnt_q + epb) >= CNT_W'(vl_q);

  // Lane unpack, vl masking and balanced reduction tree over one beat.
  always_comb begin
    // NOTE: every element gets a default before the SEW-specific unpack, so
    // no path leaves an entry unassigned and no latch is inferred.
    ident = identity(op_q, sew_q);
    for (int k = 0; k < NP; k++) elem[k] = ident;
    case (sew_q)
      2'd0:    for (int k = 0; k < NE; k++)
                 elem[k] = sext_sew(2'd0, {24'd0, bus.i_beat_data[8*k +: 8]});
      2'd1:    for (int k = 0; k < 2 * LANES; k++)
                 elem[k] = sext_sew(2'd1, {16'd0, bus.i_beat_data[16*k +: 16]});
      default: for (int k = 0; k < LANES; k++)
                 elem[k] = bus.i_beat_data[32*k +: 32];
    endcase
    for (int k = 0; k < NE; k++) begin
      if ((cnt_q + CNT_W'(k)) >= CNT_W'(vl_q)) elem[k] = ident;
    end
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < (NP >> (l + 1)); i++) begin
        elem[i] = alu(op_q, elem[2*i], elem[2*i+1]);
      end
    end
    tree_out = elem[0];
  end

  assign acc_fold = sext_sew(sew_q, alu(op_q, acc_q, tree_out));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad || (bus.i_vl == '0)) state_d = S_DONE;
          else                             state_d = S_ACCUM;
        end
      end
      S_ACCUM: if (beat_fire && last_beat) state_d = S_DONE;
      S_DONE:  if (bus.i_result_ready)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an aborted reduction leaves
  // no partial accumulator visible on o_result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q  <= '0;
      sew_q <= '0;
      vl_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q  <= bus.i_op;
            sew_q <= bus.i_vsew;
            vl_q  <= bus.i_vl;
            cnt_q <= '0;
            err_q <= cmd_bad;
            acc_q <= cmd_bad ? 32'd0 : sext_sew(bus.i_vsew, bus.i_vs1_e0);
          end
        end
        S_ACCUM: begin
          if (beat_fire) begin
            acc_q <= acc_fold;
            cnt_q <= cnt_q + epb;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready        = (state_q == S_IDLE);
  assign bus.o_beat_ready   = (state_q == S_ACCUM);
  assign bus.o_result_valid = (state_q == S_DONE);
  assign bus.o_result       = acc_q;
  assign bus.o_error        = err_q;

endmodule

// File: tb/tb_v_red_seq_unit.sv
// Self-checking bench for v_red_seq_unit: directed vector table, random SUM/MAX
// vectors against a per-element model, stall/bubble handling and mid-operation reset.
module tb_v_red_seq_unit;
  localparam int LANES = 4;
  localparam int VL_W  = 9;
  localparam int BW    = 32 * LANES;
  localparam int MAXB  = 10;
  localparam int NTAB  = 9;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  v_red_seq_unit_if #(.LANES(LANES), .VL_W(VL_W)) bus ();

  v_red_seq_unit #(.LANES(LANES), .VL_W(VL_W)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [2:0]                op;
    logic [1:0]                sew;
    logic [VL_W-1:0]           vl;
    logic [31:0]               vs1;
    logic [MAXB-1:0][BW-1:0]   beats;
    logic [3:0]                nbeats;
    logic [31:0]               res;
    logic                      err;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[NTAB];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] sew,
                              input int vl, input logic [31:0] vs1, input int nb,
                              input logic [31:0] res, input logic err);
    vec_t v;
    v        = '0;
    v.op     = op;
    v.sew    = sew;
    v.vl     = VL_W'(vl);
    v.vs1    = vs1;
    v.nbeats = 4'(nb);
    v.res    = res;
    v.err    = err;
    return v;
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] x, input int w);
    logic signed [31:0] r;
    r = x << (32 - w);
    return r >>> (32 - w);
  endfunction

  // Element-at-a-time reference: walks indices 0..vl-1 in order.
  function automatic logic [31:0] model(input vec_t v);
    int w, epb;
    logic signed [31:0] acc, e;
    logic [BW-1:0] t;
    w   = 8 << v.sew;
    epb = BW / w;
    acc = sx(v.vs1, w);
    for (int i = 0; i < int'(v.vl); i++) begin
      t = v.beats[i / epb] >> ((i % epb) * w);
      e = sx(t[31:0], w);
      if (v.op == 3'd1) acc = sx(acc + e, w);
      else if (e > acc) acc = e;
    end
    return acc;
  endfunction

  task automatic idle_inputs();
    bus.i_valid        = 1'b0;
    bus.i_op           = '0;
    bus.i_vsew         = '0;
    bus.i_vl           = '0;
    bus.i_vs1_e0       = '0;
    bus.i_beat_valid   = 1'b0;
    bus.i_beat_data    = '0;
    bus.i_result_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    sb.delete();
  endtask

  // Offers a command; after acceptance keeps a stray command on i_valid to
  // confirm the engine ignores it while busy.
  task automatic send_cmd(input vec_t v, input string tag);
    logic rdy;
    exp_t e;
    bus.i_op     = v.op;
    bus.i_vsew   = v.sew;
    bus.i_vl     = v.vl;
    bus.i_vs1_e0 = v.vs1;
    bus.i_valid  = 1'b1;
    @(negedge clk);
    rdy = bus.o_ready;
    check({tag, "_cmd_ready"}, 32'(rdy), 32'd1);
    @(posedge clk);
    e.res = v.res;
    e.err = v.err;
    if (rdy) sb.push_back(e);
    #1;
    bus.i_op     = 3'd1;
    bus.i_vsew   = 2'd2;
    bus.i_vl     = '1;
    bus.i_vs1_e0 = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit bubbles, input int hold);
    int   acc_cnt, bi, cyc, last_cyc;
    bit   got;
    exp_t e;
    logic [31:0] r0;
    logic        e0;
    send_cmd(v, tag);
    acc_cnt  = 0;
    bi       = 0;
    cyc      = 0;
    last_cyc = -10;
    got      = 1'b0;
    while (!got && cyc < 200) begin
      if (bubbles && ($urandom_range(0, 3) == 0)) begin
        bus.i_beat_valid = 1'b0;
      end else begin
        bus.i_beat_valid = 1'b1;
        if (bi < int'(v.nbeats)) bus.i_beat_data = v.beats[bi];
        else for (int l = 0; l < LANES; l++) bus.i_beat_data[32*l +: 32] = $urandom;
      end
      @(negedge clk);
      if (bus.o_result_valid) begin
        got = 1'b1;
      end else begin
        if (bus.i_beat_valid && bus.o_beat_ready) begin
          acc_cnt++;
          bi++;
          last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    bus.i_beat_valid = 1'b0;
    bus.i_valid      = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    if (!got) begin
      do_reset();
      return;
    end
    check({tag, "_beats"}, acc_cnt, 32'(v.nbeats));
    check({tag, "_latency"}, cyc, (v.nbeats == 0) ? 32'd0 : 32'(last_cyc + 1));
    r0 = bus.o_result;
    e0 = bus.o_error;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.o_result_valid), 32'd1);
      check({tag, "_hold_result"}, bus.o_result, r0);
      check({tag, "_hold_error"}, 32'(bus.o_error), 32'(e0));
    end
    bus.i_result_ready = 1'b1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, bus.o_result, e.res);
      check({tag, "_error"}, 32'(bus.o_error), 32'(e.err));
    end
    @(posedge clk);
    #1 bus.i_result_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(bus.o_result_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   epb;

    // Directed table: {op, sew, vl, vs1, beats, expected result, expected error}.
    tbl[0] = mk(3'd1, 2'd2, 4, 32'd10, 1, 32'd20, 1'b0);
    tbl[0].beats[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    tbl[1] = mk(3'd1, 2'd0, 20, 32'd0, 2, 32'h0000_0040, 1'b0);
    tbl[1].beats[0] = {16{8'h10}};
    tbl[1].beats[1] = {16{8'h10}};
    tbl[2] = mk(3'd2, 2'd1, 3, 32'h0000_FFFF, 1, 32'h0000_0007, 1'b0);
    tbl[2].beats[0] = {{5{16'h7FFF}}, 16'hFFFE, 16'h0007, 16'hFFFB};
    tbl[3] = mk(3'd1, 2'd0, 0, 32'h0000_0085, 0, 32'hFFFF_FF85, 1'b0);
    tbl[4] = mk(3'd1, 2'd3, 4, 32'h1234_5678, 0, 32'd0, 1'b1);
    tbl[5] = mk(3'd0, 2'd2, 4, 32'h1234_5678, 0, 32'd0, 1'b1);
    tbl[6] = mk(3'd2, 2'd2, 5, 32'h8000_0000, 2, 32'hFFFF_FFFF, 1'b0);
    tbl[6].beats[0] = {-32'sd100, -32'sd3, -32'sd7, -32'sd1};
    tbl[6].beats[1] = {32'd300, 32'd200, 32'd100, -32'sd2};
    tbl[7] = mk(3'd1, 2'd1, 9, 32'h0000_0001, 2, 32'h0000_0001, 1'b0);
    tbl[7].beats[0] = {8{16'h1000}};
    tbl[7].beats[1] = {{7{16'h1234}}, 16'h8000};
    tbl[8] = mk(3'd2, 2'd0, 16, 32'h0000_0080, 1, 32'h0000_0007, 1'b0);
    for (int k = 0; k < 16; k++) tbl[8].beats[0][8*k +: 8] = 8'(k - 8);

    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_beat_ready", 32'(bus.o_beat_ready), 32'd0);
    check("rst_result_valid", 32'(bus.o_result_valid), 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    check("rst_error", 32'(bus.o_error), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NTAB; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i), (i % 2) == 1, (i == 4) ? 3 : 0);
    end

    // Random SUM/MAX vectors checked against the element-order model.
    for (int r = 0; r < 6; r++) begin
      v     = '0;
      v.op  = 3'($urandom_range(1, 2));
      v.sew = 2'($urandom_range(0, 2));
      v.vl  = VL_W'($urandom_range(1, 40));
      v.vs1 = $urandom;
      for (int b = 0; b < MAXB; b++)
        for (int l = 0; l < LANES; l++) v.beats[b][32*l +: 32] = $urandom;
      epb      = BW / (8 << v.sew);
      v.nbeats = 4'((int'(v.vl) + epb - 1) / epb);
      v.res    = model(v);
      v.err    = 1'b0;
      run_vec(v, $sformatf("rnd%0d", r), 1'b1, r % 2);
    end

    // Reset during ACCUM after the first of two beats, then a fresh command.
    v = mk(3'd1, 2'd2, 8, 32'd5, 2, 32'd0, 1'b0);
    send_cmd(v, "abort");
    bus.i_beat_data  = {32'd40, 32'd30, 32'd20, 32'd10};
    bus.i_beat_valid = 1'b1;
    @(negedge clk);
    check("abort_beat_ready", 32'(bus.o_beat_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_beat_valid = 1'b0;
    bus.i_valid      = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("abort_ready", 32'(bus.o_ready), 32'd1);
    check("abort_beat_ready_rst", 32'(bus.o_beat_ready), 32'd0);
    check("abort_result_valid", 32'(bus.o_result_valid), 32'd0);
    check("abort_result", bus.o_result, 32'd0);
    check("abort_error", 32'(bus.o_error), 32'd0);
    sb.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    v = mk(3'd1, 2'd2, 1, 32'd1, 1, 32'd3, 1'b0);
    v.beats[0] = {32'd99, 32'd99, 32'd99, 32'd2};
    run_vec(v, "post_rst", 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
